// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the two-port data-memory arbiter.
// FSM states, requester ids and transfer-length codes.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER0 = 2'd1,
        XFER1 = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    localparam logic LEN_BYTE = 1'b0;
    localparam logic LEN_WORD = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester pair plus byte-wide memory bus seen by mem_arbiter.
// master: requesters and memory model; slave: the arbiter itself.
interface mem_arbiter_if #(
    parameter int ADDR_W = 13,
    parameter int BYTE_W = 8
);
    logic                req0, req1;
    logic                we0, we1;
    logic                len0, len1;
    logic [ADDR_W-1:0]   addr0, addr1;
    logic [2*BYTE_W-1:0] wdata0, wdata1;
    logic                ack0, ack1;
    logic [2*BYTE_W-1:0] rdata0, rdata1;
    logic [ADDR_W-1:0]   mem_addr;
    logic [BYTE_W-1:0]   mem_wdata;
    logic [BYTE_W-1:0]   mem_rdata;
    logic                mem_read_en;
    logic                mem_write_en;
    logic                busy;

    modport master (
        output req0, req1, we0, we1, len0, len1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  ack0, ack1, rdata0, rdata1, mem_addr, mem_wdata, mem_read_en, mem_write_en, busy
    );

    modport slave (
        input  req0, req1, we0, we1, len0, len1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output ack0, ack1, rdata0, rdata1, mem_addr, mem_wdata, mem_read_en, mem_write_en, busy
    );
endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Combinational two-requester picker; round-robin on last_grant by default.
// MEM_ARB_FIXED_PRIO_EN selects fixed priority with port 0 winning ties.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);
    assign grant_valid = req0 | req1;

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign grant_id = req0 ? PORT_CPU : PORT_DMA;
`else
    always_comb begin
        grant_id = PORT_CPU;
        if (req0 && req1) begin
            grant_id = ~last_grant;
        end else if (req1) begin
            grant_id = PORT_DMA;
        end
    end
`endif
endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for a single-port byte memory; byte ack 2 cycles, word ack 3 cycles after grant.
// Optional MEM_ARB_FIXED_PRIO_EN: port 0 wins every tie instead of round-robin.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 13,
    parameter int BYTE_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    state_t              state_q;
    logic                last_grant_q;
    logic                id_q, we_q, len_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [BYTE_W-1:0]   wdata_hi_q;
    logic [BYTE_W-1:0]   byte0_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [BYTE_W-1:0]   mem_wdata_q;
    logic                mem_re_q, mem_we_q;
    logic                ack0_q, ack1_q, busy_q;
    logic [2*BYTE_W-1:0] rdata0_q, rdata1_q;
    logic [2*BYTE_W-1:0] rdata_d;

    logic                grant_valid, grant_id;
    logic                sel_we, sel_len;
    logic [ADDR_W-1:0]   sel_addr;
    logic [2*BYTE_W-1:0] sel_wdata;

    rr_arb2 u_arb (
        .req0        (bus.req0),
        .req1        (bus.req1),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign sel_we    = (grant_id == PORT_DMA) ? bus.we1    : bus.we0;
    assign sel_len   = (grant_id == PORT_DMA) ? bus.len1   : bus.len0;
    assign sel_addr  = (grant_id == PORT_DMA) ? bus.addr1  : bus.addr0;
    assign sel_wdata = (grant_id == PORT_DMA) ? bus.wdata1 : bus.wdata0;

    // The last byte of a read arrives only in RESP, so assembly is combinational there.
    assign rdata_d = (len_q == LEN_WORD) ? {bus.mem_rdata, byte0_q}
                                         : {{BYTE_W{1'b0}}, bus.mem_rdata};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= PORT_DMA;
            id_q         <= PORT_CPU;
            we_q         <= 1'b0;
            len_q        <= LEN_BYTE;
            addr_q       <= '0;
            wdata_hi_q   <= '0;
            byte0_q      <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            busy_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_valid) begin
                        state_q      <= XFER0;
                        last_grant_q <= grant_id;
                        id_q         <= grant_id;
                        we_q         <= sel_we;
                        len_q        <= sel_len;
                        addr_q       <= sel_addr;
                        wdata_hi_q   <= sel_wdata[2*BYTE_W-1:BYTE_W];
                        mem_addr_q   <= sel_addr;
                        mem_wdata_q  <= sel_wdata[BYTE_W-1:0];
                        mem_we_q     <= sel_we;
                        mem_re_q     <= ~sel_we;
                        busy_q       <= 1'b1;
                    end
                end
                XFER0: begin
                    if (len_q == LEN_WORD) begin
                        state_q     <= XFER1;
                        mem_addr_q  <= addr_q + ADDR_W'(1);
                        mem_wdata_q <= wdata_hi_q;
                    end else begin
                        state_q  <= RESP;
                        mem_re_q <= 1'b0;
                        mem_we_q <= 1'b0;
                        ack0_q   <= (id_q == PORT_CPU);
                        ack1_q   <= (id_q == PORT_DMA);
                    end
                end
                XFER1: begin
                    if (!we_q) begin
                        byte0_q <= bus.mem_rdata;
                    end
                    state_q  <= RESP;
                    mem_re_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    ack0_q   <= (id_q == PORT_CPU);
                    ack1_q   <= (id_q == PORT_DMA);
                end
                RESP: begin
                    state_q <= IDLE;
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    if (!we_q) begin
                        if (id_q == PORT_DMA) rdata1_q <= rdata_d;
                        else                  rdata0_q <= rdata_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ack0         = ack0_q;
    assign bus.ack1         = ack1_q;
    assign bus.rdata0       = (state_q == RESP && !we_q && id_q == PORT_CPU) ? rdata_d : rdata0_q;
    assign bus.rdata1       = (state_q == RESP && !we_q && id_q == PORT_DMA) ? rdata_d : rdata1_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.mem_read_en  = mem_re_q;
    assign bus.mem_write_en = mem_we_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, arbitration and reset corner sequences.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(13), .BYTE_W(8)) bus ();
    mem_arbiter #(.ADDR_W(13), .BYTE_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct { logic p; logic [15:0] rd; } ack_exp_t;
    typedef struct { logic [12:0] a; logic [7:0] d; } wr_exp_t;
    typedef struct {
        logic        p;
        logic        we;
        logic        len;
        logic [12:0] a;
        logic [15:0] wd;
        logic [15:0] rd;
    } vec_t;

    ack_exp_t ack_q[$];
    wr_exp_t  wr_q[$];
    int checks = 0;
    int errors = 0;
    logic [7:0] mem [0:8191];

    // Byte memory with one-cycle registered read
    always @(posedge clk) begin
        if (bus.mem_write_en) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_read_en)  bus.mem_rdata <= mem[bus.mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        ack_exp_t e;
        wr_exp_t  w;
        if (!rst) begin
            chk("enables_exclusive", 32'(bus.mem_read_en & bus.mem_write_en), 0);
            chk("acks_exclusive", 32'(bus.ack0 & bus.ack1), 0);
            if (bus.ack0 || bus.ack1) begin
                if (ack_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL ack_unexpected: got ack0=%0b ack1=%0b expected none", bus.ack0, bus.ack1);
                end else begin
                    e = ack_q.pop_front();
                    chk("ack_port", 32'(bus.ack1), 32'(e.p));
                    chk("ack_rdata", 32'(bus.ack1 ? bus.rdata1 : bus.rdata0), 32'(e.rd));
                end
            end
            if (bus.mem_write_en) begin
                if (wr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL write_unexpected: got addr %0h data %0h expected none", bus.mem_addr, bus.mem_wdata);
                end else begin
                    w = wr_q.pop_front();
                    chk("write_addr", 32'(bus.mem_addr), 32'(w.a));
                    chk("write_data", 32'(bus.mem_wdata), 32'(w.d));
                end
            end
        end
    end

    task automatic drive(input logic p, input logic r, input logic we, input logic len,
                         input logic [12:0] a, input logic [15:0] wd);
        if (p) begin
            bus.req1 = r; bus.we1 = we; bus.len1 = len; bus.addr1 = a; bus.wdata1 = wd;
        end else begin
            bus.req0 = r; bus.we0 = we; bus.len0 = len; bus.addr0 = a; bus.wdata0 = wd;
        end
    endtask

    task automatic push_ack(input logic p, input logic [15:0] rd);
        ack_exp_t e;
        e.p = p; e.rd = rd;
        ack_q.push_back(e);
    endtask

    task automatic push_wr(input logic [12:0] a, input logic [7:0] d);
        wr_exp_t w;
        w.a = a; w.d = d;
        wr_q.push_back(w);
    endtask

    task automatic issue(input vec_t v);
        int lat;
        @(negedge clk);
        drive(v.p, 1'b1, v.we, v.len, v.a, v.wd);
        push_ack(v.p, v.rd);
        if (v.we) begin
            push_wr(v.a, v.wd[7:0]);
            if (v.len) push_wr(v.a + 13'd1, v.wd[15:8]);
        end
        lat = 0;
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            @(negedge clk);
            if (v.p ? bus.ack1 : bus.ack0) lat = c;
        end
        chk("ack_latency", lat, v.len ? 3 : 2);
        drive(v.p, 1'b0, 1'b0, 1'b0, 13'h0, 16'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[9];
        vec_t v;
        int   n, a0, a1;

        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
        bus.mem_rdata = 8'h00;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 13'h0, 16'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 13'h0, 16'h0);

        //        port  we    len   addr      wdata     expected rdata
        vt[0] = '{1'b0, 1'b1, 1'b0, 13'h0010, 16'h00A5, 16'h0000};
        vt[1] = '{1'b0, 1'b0, 1'b0, 13'h0010, 16'h0000, 16'h00A5};
        vt[2] = '{1'b1, 1'b1, 1'b1, 13'h1FFF, 16'hBEEF, 16'h0000};
        vt[3] = '{1'b1, 1'b0, 1'b1, 13'h1FFF, 16'h0000, 16'hBEEF};
        vt[4] = '{1'b0, 1'b1, 1'b1, 13'h0200, 16'h1357, 16'h00A5};
        vt[5] = '{1'b1, 1'b0, 1'b0, 13'h0201, 16'h0000, 16'h0013};
        vt[6] = '{1'b0, 1'b0, 1'b1, 13'h0200, 16'h0000, 16'h1357};
        vt[7] = '{1'b1, 1'b1, 1'b0, 13'h0020, 16'hFF5A, 16'h0013};
        vt[8] = '{1'b0, 1'b0, 1'b1, 13'h001F, 16'h0000, 16'h5A00};

        repeat (3) @(negedge clk);
        chk("reset_ack0", 32'(bus.ack0), 0);
        chk("reset_ack1", 32'(bus.ack1), 0);
        chk("reset_rdata0", 32'(bus.rdata0), 0);
        chk("reset_rdata1", 32'(bus.rdata1), 0);
        chk("reset_mem_addr", 32'(bus.mem_addr), 0);
        chk("reset_mem_wdata", 32'(bus.mem_wdata), 0);
        chk("reset_read_en", 32'(bus.mem_read_en), 0);
        chk("reset_write_en", 32'(bus.mem_write_en), 0);
        chk("reset_busy", 32'(bus.busy), 0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) issue(vt[i]);

        // Both ports held from reset: round-robin alternates, fixed priority keeps port 0
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 13'h0010, 16'h0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 13'h1FFF, 16'h0);
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            push_ack(1'b0, 16'h00A5);
`else
            push_ack(k[0], k[0] ? 16'h00EF : 16'h00A5);
`endif
        end
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            if (bus.ack0 || bus.ack1) begin
                n++;
                if (n == 4) begin
                    drive(1'b0, 1'b0, 1'b0, 1'b0, 13'h0, 16'h0);
                    drive(1'b1, 1'b0, 1'b0, 1'b0, 13'h0, 16'h0);
                end
            end
        end
        chk("rr_ack_count", n, 4);

        // Port 1 arrives while port 0 is in XFER0
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 13'h0010, 16'h0);
        push_ack(1'b0, 16'h00A5);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 13'h1FFF, 16'h0);
        push_ack(1'b1, 16'h00EF);
        a0 = 0; a1 = 0;
        for (int c = 2; c <= 12 && a1 == 0; c++) begin
            @(negedge clk);
            if (bus.ack0) begin a0 = c; drive(1'b0, 1'b0, 1'b0, 1'b0, 13'h0, 16'h0); end
            if (bus.ack1) begin a1 = c; drive(1'b1, 1'b0, 1'b0, 1'b0, 13'h0, 16'h0); end
        end
        chk("contend_ack0_cycle", a0, 2);
        chk("contend_ack1_cycle", a1, 5);

        // Reset during XFER1 of a word write
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 13'h0100, 16'h1234);
        push_wr(13'h0100, 8'h34);
        push_wr(13'h0101, 8'h12);
        @(negedge clk);
        chk("xfer0_addr", 32'(bus.mem_addr), 32'h0100);
        @(negedge clk);
        chk("xfer1_addr", 32'(bus.mem_addr), 32'h0101);
        chk("xfer1_write_en", 32'(bus.mem_write_en), 1);
        #1 rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 13'h0, 16'h0);
        #1;
        chk("midrst_write_en", 32'(bus.mem_write_en), 0);
        chk("midrst_read_en", 32'(bus.mem_read_en), 0);
        chk("midrst_mem_addr", 32'(bus.mem_addr), 0);
        chk("midrst_mem_wdata", 32'(bus.mem_wdata), 0);
        chk("midrst_busy", 32'(bus.busy), 0);
        chk("midrst_rdata0", 32'(bus.rdata0), 0);
        ack_q.delete();
        wr_q.delete();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("midrst_no_ack", 32'(bus.ack0 | bus.ack1), 0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", 32'(bus.busy), 0);
        chk("post_rst_no_ack", 32'(bus.ack0 | bus.ack1), 0);
        v = '{1'b0, 1'b0, 1'b0, 13'h0100, 16'h0000, 16'h0034};
        issue(v);
        v = '{1'b1, 1'b0, 1'b1, 13'h0100, 16'h0000, 16'h0034};
        issue(v);

        repeat (2) @(negedge clk);
        chk("pending_acks", ack_q.size(), 0);
        chk("pending_writes", wr_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
